// File: rtl/vend_ctrl.sv
// Main control FSM of the auto-buy vending machine: item selection, payment in
// half-yuan units, dispensing with change, and refund on cancel or inactivity.
module vend_ctrl #(
   parameter logic [7:0] PRICE0    = 8'd4,
   parameter logic [7:0] PRICE1    = 8'd5,
   parameter logic [7:0] PRICE2    = 8'd7,
   parameter logic [7:0] PRICE3    = 8'd10,
   parameter logic [3:0] TIMEOUT_S = 4'd10
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic       key_sel,
   input  logic       key_ok,
   input  logic       key_cancel,
   input  logic       coin_half,
   input  logic       coin_one,
   input  logic       tick_1s,
   input  logic       flag_2s,
   output logic       flag_charge,
   output logic [1:0] state,
   output logic [1:0] item_idx,
   output logic [7:0] price,
   output logic [7:0] money_sum,
   output logic [7:0] change_out,
   output logic       goods_out,
   output logic       coin_reject
);

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_PAY      = 2'd1,
      ST_DISPENSE = 2'd2,
      ST_REFUND   = 2'd3
   } state_t;

   state_t     r_state,  w_state_n;
   logic [1:0] r_item,   w_item_n;
   logic [7:0] r_price,  w_price_n;
   logic [7:0] r_money,  w_money_n;
   logic [7:0] r_change, w_change_n;
   logic       r_goods,  w_goods_n;
   logic       r_charge, w_charge_n;
   logic       r_reject, w_reject_n;
   logic [3:0] r_sec,    w_sec_n;

   logic       w_coin_any;
   logic [7:0] w_coin_val;
   logic [7:0] w_sum_next;
   logic [3:0] w_sec_inc;

   // half = 1 unit, one = 2 units; both together give 3
   assign w_coin_val = {6'd0, coin_one, coin_half};
   assign w_coin_any = coin_half | coin_one;
   assign w_sum_next = r_money + w_coin_val;
   assign w_sec_inc  = r_sec + 4'd1;

   always_comb begin
      w_state_n  = r_state;
      w_item_n   = r_item;
      w_money_n  = r_money;
      w_change_n = r_change;
      w_goods_n  = r_goods;
      w_charge_n = r_charge;
      w_reject_n = 1'b0;
      w_sec_n    = r_sec;
      // price follows the registered item index, one cycle behind
      case (r_item)
         2'd0:    w_price_n = PRICE0;
         2'd1:    w_price_n = PRICE1;
         2'd2:    w_price_n = PRICE2;
         default: w_price_n = PRICE3;
      endcase

      case (r_state)
         ST_IDLE: begin
            w_reject_n = w_coin_any;
            if (key_ok) begin
               w_state_n = ST_PAY;
               w_money_n = 8'd0;
               w_sec_n   = 4'd0;
            end else if (key_sel) begin
               w_item_n = r_item + 2'd1;
            end
         end
         ST_PAY: begin
            if (key_cancel) begin
               w_state_n  = ST_REFUND;
               w_money_n  = w_sum_next;
               w_change_n = w_sum_next;
               w_charge_n = 1'b1;
            end else if (w_coin_any) begin
               w_money_n = w_sum_next;
               w_sec_n   = 4'd0;
               if (w_sum_next >= r_price) begin
                  w_state_n  = ST_DISPENSE;
                  w_goods_n  = 1'b1;
                  w_charge_n = 1'b1;
                  w_change_n = w_sum_next - r_price;
               end
            end else if (tick_1s) begin
               w_sec_n = w_sec_inc;
               if (w_sec_inc >= TIMEOUT_S) begin
                  w_sec_n = 4'd0;
                  if (r_money != 8'd0) begin
                     w_state_n  = ST_REFUND;
                     w_change_n = r_money;
                     w_charge_n = 1'b1;
                  end else begin
                     w_state_n = ST_IDLE;
                  end
               end
            end
         end
         ST_DISPENSE, ST_REFUND: begin
            // outputs hold until the timer's 2 s charge period completes
            w_reject_n = w_coin_any;
            if (flag_2s) begin
               w_state_n  = ST_IDLE;
               w_money_n  = 8'd0;
               w_change_n = 8'd0;
               w_goods_n  = 1'b0;
               w_charge_n = 1'b0;
            end
         end
         default: w_state_n = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state  <= ST_IDLE;
         r_item   <= 2'd0;
         r_price  <= PRICE0;
         r_money  <= 8'd0;
         r_change <= 8'd0;
         r_goods  <= 1'b0;
         r_charge <= 1'b0;
         r_reject <= 1'b0;
         r_sec    <= 4'd0;
      end else begin
         r_state  <= w_state_n;
         r_item   <= w_item_n;
         r_price  <= w_price_n;
         r_money  <= w_money_n;
         r_change <= w_change_n;
         r_goods  <= w_goods_n;
         r_charge <= w_charge_n;
         r_reject <= w_reject_n;
         r_sec    <= w_sec_n;
      end
   end

   assign state       = r_state;
   assign item_idx    = r_item;
   assign price       = r_price;
   assign money_sum   = r_money;
   assign change_out  = r_change;
   assign goods_out   = r_goods;
   assign flag_charge = r_charge;
   assign coin_reject = r_reject;

endmodule

// File: tb/tb_vend_ctrl.sv
// Self-checking bench for vend_ctrl: expected output snapshots are queued as
// stimulus is driven and compared after the clock edge that produces them.
module tb_vend_ctrl;

   // Expected vector layout: {state, item, price, money, change, goods, charge, reject}
   localparam logic [6:0] K_SEL  = 7'b1000000;
   localparam logic [6:0] K_OK   = 7'b0100000;
   localparam logic [6:0] K_CAN  = 7'b0010000;
   localparam logic [6:0] C_HALF = 7'b0001000;
   localparam logic [6:0] C_ONE  = 7'b0000100;
   localparam logic [6:0] T_1S   = 7'b0000010;
   localparam logic [6:0] F_2S   = 7'b0000001;
   localparam logic [6:0] NONE   = 7'b0000000;

   logic       clk;
   logic       rstn;
   logic       key_sel, key_ok, key_cancel, coin_half, coin_one, tick_1s, flag_2s;
   logic       flag_charge, goods_out, coin_reject;
   logic [1:0] state, item_idx;
   logic [7:0] price, money_sum, change_out;

   logic [30:0] exp_q[$];
   logic [30:0] exp_v, got_v;
   int          n_total;
   int          n_pass;

   vend_ctrl dut (
      .clk         (clk),
      .rstn        (rstn),
      .key_sel     (key_sel),
      .key_ok      (key_ok),
      .key_cancel  (key_cancel),
      .coin_half   (coin_half),
      .coin_one    (coin_one),
      .tick_1s     (tick_1s),
      .flag_2s     (flag_2s),
      .flag_charge (flag_charge),
      .state       (state),
      .item_idx    (item_idx),
      .price       (price),
      .money_sum   (money_sum),
      .change_out  (change_out),
      .goods_out   (goods_out),
      .coin_reject (coin_reject)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #10 clk = ~clk;

   function automatic logic [30:0] pk(input logic [1:0] st, input logic [1:0] it,
                                      input logic [7:0] pr, input logic [7:0] mo,
                                      input logic [7:0] ch, input logic gd,
                                      input logic cg, input logic rj);
      return {st, it, pr, mo, ch, gd, cg, rj};
   endfunction

   function automatic logic [30:0] obs();
      return {state, item_idx, price, money_sum, change_out, goods_out, flag_charge, coin_reject};
   endfunction

   // ---------------- driver ----------------
   task automatic drive(input logic [6:0] v);
      @(negedge clk);
      {key_sel, key_ok, key_cancel, coin_half, coin_one, tick_1s, flag_2s} = v;
      @(posedge clk);
      #1;
      {key_sel, key_ok, key_cancel, coin_half, coin_one, tick_1s, flag_2s} = NONE;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rstn = 1'b0;
      {key_sel, key_ok, key_cancel, coin_half, coin_one, tick_1s, flag_2s} = NONE;
      exp_q.push_back(pk(2'd0, 2'd0, 8'd4, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0));
      repeat (3) @(posedge clk);
      #1;
      got_v = obs(); exp_v = exp_q.pop_front(); n_total++;
      if (got_v !== exp_v) $display("FAIL reset_values got=%h exp=%h", got_v, exp_v); else n_pass++;
      @(negedge clk);
      rstn = 1'b1;
   endtask

   task automatic test_select();
      repeat (5) drive(K_SEL);
      exp_q.push_back(pk(2'd0, 2'd1, 8'd5, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0));
      drive(NONE);
      got_v = obs(); exp_v = exp_q.pop_front(); n_total++;
      if (got_v !== exp_v) $display("FAIL select_x5 got=%h exp=%h", got_v, exp_v); else n_pass++;
      repeat (3) drive(K_SEL);
      exp_q.push_back(pk(2'd0, 2'd0, 8'd4, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0));
      drive(NONE);
      got_v = obs(); exp_v = exp_q.pop_front(); n_total++;
      if (got_v !== exp_v) $display("FAIL select_wrap got=%h exp=%h", got_v, exp_v); else n_pass++;
   endtask

   task automatic test_dispense_exact();
      exp_q.push_back(pk(2'd1, 2'd0, 8'd4, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0));
      drive(K_OK);
      got_v = obs(); exp_v = exp_q.pop_front(); n_total++;
      if (got_v !== exp_v) $display("FAIL exact_enter_pay got=%h exp=%h", got_v, exp_v); else n_pass++;
      exp_q.push_back(pk(2'd1, 2'd0, 8'd4, 8'd2, 8'd0, 1'b0, 1'b0, 1'b0));
      drive(C_ONE);
      got_v = obs(); exp_v = exp_q.pop_front(); n_total++;
      if (got_v !== exp_v) $display("FAIL exact_coin1 got=%h exp=%h", got_v, exp_v); else n_pass++;
      exp_q.push_back(pk(2'd2, 2'd0, 8'd4, 8'd4, 8'd0, 1'b1, 1'b1, 1'b0));
      drive(C_ONE);
      got_v = obs(); exp_v = exp_q.pop_front(); n_total++;
      if (got_v !== exp_v) $display("FAIL exact_dispense got=%h exp=%h", got_v, exp_v); else n_pass++;
      exp_q.push_back(pk(2'd2, 2'd0, 8'd4, 8'd4, 8'd0, 1'b1, 1'b1, 1'b0));
      drive(K_SEL | K_CAN | T_1S);
      got_v = obs(); exp_v = exp_q.pop_front(); n_total++;
      if (got_v !== exp_v) $display("FAIL exact_hold got=%h exp=%h", got_v, exp_v); else n_pass++;
      exp_q.push_back(pk(2'd0, 2'd0, 8'd4, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0));
      drive(F_2S);
      got_v = obs(); exp_v = exp_q.pop_front(); n_total++;
      if (got_v !== exp_v) $display("FAIL exact_back_idle got=%h exp=%h", got_v, exp_v); else n_pass++;
   endtask

   task automatic test_change();
      repeat (2) drive(K_SEL);
      drive(NONE);
      drive(K_OK);
      repeat (3) drive(C_ONE);
      exp_q.push_back(pk(2'd1, 2'd2, 8'd7, 8'd6, 8'd0, 1'b0, 1'b0, 1'b0));
      drive(NONE);
      got_v = obs(); exp_v = exp_q.pop_front(); n_total++;
      if (got_v !== exp_v) $display("FAIL change_partial got=%h exp=%h", got_v, exp_v); else n_pass++;
      exp_q.push_back(pk(2'd2, 2'd2, 8'd7, 8'd9, 8'd2, 1'b1, 1'b1, 1'b0));
      drive(C_HALF | C_ONE);
      got_v = obs(); exp_v = exp_q.pop_front(); n_total++;
      if (got_v !== exp_v) $display("FAIL change_dispense got=%h exp=%h", got_v, exp_v); else n_pass++;
      exp_q.push_back(pk(2'd2, 2'd2, 8'd7, 8'd9, 8'd2, 1'b1, 1'b1, 1'b1));
      drive(C_ONE);
      got_v = obs(); exp_v = exp_q.pop_front(); n_total++;
      if (got_v !== exp_v) $display("FAIL reject_dispense got=%h exp=%h", got_v, exp_v); else n_pass++;
      exp_q.push_back(pk(2'd0, 2'd2, 8'd7, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0));
      drive(F_2S);
      got_v = obs(); exp_v = exp_q.pop_front(); n_total++;
      if (got_v !== exp_v) $display("FAIL change_back_idle got=%h exp=%h", got_v, exp_v); else n_pass++;
   endtask

   task automatic test_cancel();
      drive(K_SEL);
      drive(NONE);
      drive(K_OK);
      repeat (2) drive(C_ONE);
      exp_q.push_back(pk(2'd3, 2'd3, 8'd10, 8'd5, 8'd5, 1'b0, 1'b1, 1'b0));
      drive(K_CAN | C_HALF);
      got_v = obs(); exp_v = exp_q.pop_front(); n_total++;
      if (got_v !== exp_v) $display("FAIL cancel_refund got=%h exp=%h", got_v, exp_v); else n_pass++;
      exp_q.push_back(pk(2'd0, 2'd3, 8'd10, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0));
      drive(F_2S);
      got_v = obs(); exp_v = exp_q.pop_front(); n_total++;
      if (got_v !== exp_v) $display("FAIL cancel_back_idle got=%h exp=%h", got_v, exp_v); else n_pass++;
   endtask

   task automatic test_timeout();
      logic charge_seen;
      drive(K_SEL);
      drive(NONE);
      drive(K_OK);
      drive(C_HALF);
      // flag_2s in PAY must be ignored
      drive(F_2S);
      repeat (9) drive(T_1S);
      exp_q.push_back(pk(2'd1, 2'd0, 8'd4, 8'd1, 8'd0, 1'b0, 1'b0, 1'b0));
      drive(NONE);
      got_v = obs(); exp_v = exp_q.pop_front(); n_total++;
      if (got_v !== exp_v) $display("FAIL timeout_9_ticks got=%h exp=%h", got_v, exp_v); else n_pass++;
      drive(T_1S);
      exp_q.push_back(pk(2'd3, 2'd0, 8'd4, 8'd1, 8'd1, 1'b0, 1'b1, 1'b0));
      drive(NONE);
      got_v = obs(); exp_v = exp_q.pop_front(); n_total++;
      if (got_v !== exp_v) $display("FAIL timeout_refund got=%h exp=%h", got_v, exp_v); else n_pass++;
      drive(F_2S);
      // empty-handed timeout returns straight to IDLE with no charge period
      drive(K_OK);
      charge_seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         drive(T_1S);
         charge_seen = charge_seen | flag_charge;
      end
      drive(NONE);
      charge_seen = charge_seen | flag_charge;
      exp_q.push_back(pk(2'd0, 2'd0, 8'd4, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0));
      got_v = obs(); exp_v = exp_q.pop_front(); n_total++;
      if (got_v !== exp_v) $display("FAIL timeout_empty_idle got=%h exp=%h", got_v, exp_v); else n_pass++;
      n_total++;
      if (charge_seen !== 1'b0) $display("FAIL timeout_empty_charge got=%b exp=0", charge_seen); else n_pass++;
   endtask

   task automatic test_reject_idle();
      exp_q.push_back(pk(2'd0, 2'd0, 8'd4, 8'd0, 8'd0, 1'b0, 1'b0, 1'b1));
      drive(C_ONE);
      got_v = obs(); exp_v = exp_q.pop_front(); n_total++;
      if (got_v !== exp_v) $display("FAIL reject_idle got=%h exp=%h", got_v, exp_v); else n_pass++;
      exp_q.push_back(pk(2'd0, 2'd0, 8'd4, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0));
      drive(NONE);
      got_v = obs(); exp_v = exp_q.pop_front(); n_total++;
      if (got_v !== exp_v) $display("FAIL reject_pulse_end got=%h exp=%h", got_v, exp_v); else n_pass++;
   endtask

   task automatic test_back_to_back();
      // key_ok wins over key_sel in the same cycle
      exp_q.push_back(pk(2'd1, 2'd0, 8'd4, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0));
      drive(K_SEL | K_OK);
      got_v = obs(); exp_v = exp_q.pop_front(); n_total++;
      if (got_v !== exp_v) $display("FAIL sel_ok_same_cycle got=%h exp=%h", got_v, exp_v); else n_pass++;
      exp_q.push_back(pk(2'd1, 2'd0, 8'd4, 8'd3, 8'd0, 1'b0, 1'b0, 1'b0));
      drive(C_ONE | C_HALF);
      got_v = obs(); exp_v = exp_q.pop_front(); n_total++;
      if (got_v !== exp_v) $display("FAIL both_coins got=%h exp=%h", got_v, exp_v); else n_pass++;
      // asynchronous reset mid-payment
      @(negedge clk);
      rstn = 1'b0;
      #1;
      exp_q.push_back(pk(2'd0, 2'd0, 8'd4, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0));
      got_v = obs(); exp_v = exp_q.pop_front(); n_total++;
      if (got_v !== exp_v) $display("FAIL reset_mid_pay got=%h exp=%h", got_v, exp_v); else n_pass++;
      @(negedge clk);
      rstn = 1'b1;
      exp_q.push_back(pk(2'd0, 2'd1, 8'd4, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0));
      drive(K_SEL);
      got_v = obs(); exp_v = exp_q.pop_front(); n_total++;
      if (got_v !== exp_v) $display("FAIL after_reset_sel got=%h exp=%h", got_v, exp_v); else n_pass++;
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      n_total = 0;
      n_pass  = 0;
      test_reset();
      test_select();
      test_dispense_exact();
      test_change();
      test_cancel();
      test_timeout();
      test_reject_idle();
      test_back_to_back();
      if (exp_q.size() != 0) begin
         n_total++;
         $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
